// File: rtl/zigzag_pkg.sv
// Zigzag <-> raster mapping shared by the JPEG encoder and decoder paths.
// One constant table drives both directions.
package zigzag_pkg;

    localparam int BLK_SIZE = 64;

    // ZZ2R[k] = raster address (row*8 + col) of zigzag scan position k
    localparam logic [5:0] ZZ2R [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [5:0] de_zigzag(input logic [5:0] zz_idx);
        return ZZ2R[zz_idx];
    endfunction

    // Encoder direction: raster address back to zigzag position.
    function automatic logic [5:0] zigzag(input logic [5:0] raster);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < BLK_SIZE; i++) begin
            if (ZZ2R[i] == raster) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/unzigzag_if.sv
// Stream bundle for the inverse zigzag stage: two-coefficient input beats
// and eight-coefficient raster rows out, each with its own hold.
interface unzigzag_if #(
    parameter int QW = 15
);
    logic signed [QW-1:0] d [2];
    logic [4:0]           d_cnt;
    logic                 d_valid;
    logic                 d_hold;
    logic signed [QW-1:0] q [8];
    logic [2:0]           q_cnt;
    logic                 q_valid;
    logic                 q_hold;

    modport slave (
        input  d, d_cnt, d_valid, q_hold,
        output d_hold, q, q_cnt, q_valid
    );

    modport master (
        output d, d_cnt, d_valid, q_hold,
        input  d_hold, q, q_cnt, q_valid
    );
endinterface

// File: rtl/unzigzag_buf.sv
// Two-bank coefficient store: each write scatters a beat's two coefficients
// to their raster slots, each read returns one full raster row.
module unzigzag_buf
    import zigzag_pkg::*;
#(
    parameter int QW = 15
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 wbank,
    input  logic [4:0]           wbeat,
    input  logic signed [QW-1:0] wdata [2],
    input  logic                 rbank,
    input  logic [2:0]           rrow,
    output logic signed [QW-1:0] rdata [8]
);

    logic signed [QW-1:0] mem [2][BLK_SIZE];

    // Two distinct zigzag positions never share a raster slot, so both writes are safe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][de_zigzag({wbeat, 1'b0})] <= wdata[0];
            mem[wbank][de_zigzag({wbeat, 1'b1})] <= wdata[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd
            assign rdata[gi] = mem[rbank][{rrow, 3'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/unzigzag.sv
// Inverse zigzag reorder: zigzag-ordered beats in, raster rows out, with
// ping-pong banks managed as a two-entry FIFO of blocks.
module unzigzag
    import zigzag_pkg::*;
#(
    parameter int QW = 15
) (
    input  logic     clk,
    input  logic     resetn,
    unzigzag_if.slave bus
);

    logic [1:0]           wptr_reg;
    logic [1:0]           rptr_reg;
    logic [2:0]           rd_cnt_reg;
    logic                 q_valid_reg;
    logic [2:0]           q_cnt_reg;
    logic signed [QW-1:0] q_reg [8];
    logic signed [QW-1:0] rdata [8];

    logic empty;
    logic full;
    logic accept;
    logic commit;
    logic re;

    // Bit 1 of each pointer is a wrap bit; bit 0 names the bank.
    assign empty  = (wptr_reg == rptr_reg);
    assign full   = (wptr_reg[1] != rptr_reg[1]) && (wptr_reg[0] == rptr_reg[0]);
    assign accept = bus.d_valid && !full;
    assign commit = accept && (bus.d_cnt == 5'd31);
    assign re     = !empty && !bus.q_hold;

    unzigzag_buf #(
        .QW(QW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .wbank (wptr_reg[0]),
        .wbeat (bus.d_cnt),
        .wdata (bus.d),
        .rbank (rptr_reg[0]),
        .rrow  (rd_cnt_reg),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            rd_cnt_reg  <= '0;
            q_valid_reg <= 1'b0;
            q_cnt_reg   <= '0;
            for (int i = 0; i < 8; i++) begin
                q_reg[i] <= '0;
            end
        end else begin
            if (commit) begin
                wptr_reg <= wptr_reg + 2'd1;
            end
            // A stalled consumer freezes every piece of read-side state.
            if (!bus.q_hold) begin
                q_valid_reg <= re;
                if (re) begin
                    for (int i = 0; i < 8; i++) begin
                        q_reg[i] <= rdata[i];
                    end
                    q_cnt_reg  <= rd_cnt_reg;
                    rd_cnt_reg <= rd_cnt_reg + 3'd1;
                    if (rd_cnt_reg == 3'd7) begin
                        rptr_reg <= rptr_reg + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.d_hold  = full;
    assign bus.q_valid = q_valid_reg;
    assign bus.q_cnt   = q_cnt_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_q
            assign bus.q[gi] = q_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_unzigzag.sv
// Directed bench for unzigzag: table of hand-computed rows plus sequences for
// stall, backpressure and mid-block reset.
module tb_unzigzag;

    localparam int QW = 15;

    typedef struct {
        int cnt;
        int v [8];
    } row_t;

    typedef struct {
        string name;
        int    row;
        int    v [8];
    } vec_t;

    logic clk;
    logic resetn;

    unzigzag_if #(.QW(QW)) bus ();

    unzigzag #(.QW(QW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp;
    int   n_bad;
    int   rows_seen;
    int   zz2r [64];
    int   blk [64];
    int   cap [8][8];
    row_t expq [$];
    row_t mon_e;
    bit   watch_dhold;
    bit   dhold_seen;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // A row is consumed at the edge following a negedge where it is valid and unstalled.
    always @(negedge clk) begin
        if (watch_dhold && bus.d_valid && bus.d_hold) dhold_seen = 1'b1;
        if (resetn && bus.q_valid && !bus.q_hold) begin
            rows_seen++;
            $display("row q_cnt=%0d q={%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d}", bus.q_cnt,
                     bus.q[0], bus.q[1], bus.q[2], bus.q[3],
                     bus.q[4], bus.q[5], bus.q[6], bus.q[7]);
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_row: got row %0d, required no row", bus.q_cnt);
            end else begin
                mon_e = expq.pop_front();
                chk("row_q_cnt", int'(bus.q_cnt), mon_e.cnt);
                for (int i = 0; i < 8; i++) begin
                    chk("row_coef", int'(bus.q[i]), mon_e.v[i]);
                    cap[mon_e.cnt][i] = int'(bus.q[i]);
                end
            end
        end
    end

    task automatic push_model();
        row_t r;
        int   rast [64];
        for (int k = 0; k < 64; k++) rast[zz2r[k]] = blk[k];
        for (int row = 0; row < 8; row++) begin
            r.cnt = row;
            for (int i = 0; i < 8; i++) r.v[i] = rast[row*8 + i];
            expq.push_back(r);
        end
    endtask

    task automatic drive_beat(input int c);
        bus.d[0]    = QW'(blk[2*c]);
        bus.d[1]    = QW'(blk[2*c + 1]);
        bus.d_cnt   = 5'(c);
        bus.d_valid = 1'b1;
    endtask

    task automatic send_beat(input int c);
        drive_beat(c);
        for (int t = 0; ; t++) begin
            if (t > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got d_hold=1 for %0d cycles, required acceptance", t);
                break;
            end
            if (!bus.d_hold) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block();
        for (int c = 0; c < 32; c++) send_beat(c);
        bus.d_valid = 1'b0;
        push_model();
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 300 && expq.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        if (expq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d rows pending, required 0", expq.size());
            expq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_blk(input int base);
        for (int k = 0; k < 64; k++) blk[k] = base + k;
    endtask

    initial begin
        vec_t tbl [3];
        row_t hold_exp;
        int   ri;
        int   ci;
        int   r0;

        n_cmp = 0; n_bad = 0; rows_seen = 0;
        watch_dhold = 1'b0; dhold_seen = 1'b0;
        resetn = 1'b0;
        bus.d[0] = '0; bus.d[1] = '0; bus.d_cnt = '0;
        bus.d_valid = 1'b0; bus.q_hold = 1'b0;

        // Independent zigzag model: walk the anti-diagonals.
        ri = 0; ci = 0;
        for (int k = 0; k < 64; k++) begin
            zz2r[k] = ri*8 + ci;
            if (((ri + ci) % 2) == 0) begin
                if (ci == 7) ri++;
                else if (ri == 0) ci++;
                else begin ri--; ci++; end
            end else begin
                if (ri == 7) ci++;
                else if (ci == 0) ri++;
                else begin ri++; ci--; end
            end
        end

        tbl[0].name = "zzid_row0"; tbl[0].row = 0; tbl[0].v = '{0, 1, 5, 6, 14, 15, 27, 28};
        tbl[1].name = "zzid_row1"; tbl[1].row = 1; tbl[1].v = '{2, 4, 7, 13, 16, 26, 29, 42};
        tbl[2].name = "zzid_row7"; tbl[2].row = 7; tbl[2].v = '{35, 36, 48, 49, 57, 58, 62, 63};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_valid", int'(bus.q_valid), 0);
        chk("rst_q_cnt", int'(bus.q_cnt), 0);
        chk("rst_d_hold", int'(bus.d_hold), 0);
        chk("rst_q0", int'(bus.q[0]), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // One block, value = zigzag index
        fill_blk(0);
        send_block();
        chk("latency_pre_q_valid", int'(bus.q_valid), 0);
        @(posedge clk); #1;
        chk("latency_q_valid", int'(bus.q_valid), 1);
        chk("latency_q_cnt", int'(bus.q_cnt), 0);
        drain();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 8; j++) chk(tbl[i].name, cap[tbl[i].row][j], tbl[i].v[j]);
        end

        // Three back-to-back blocks, no stall
        r0 = rows_seen;
        watch_dhold = 1'b1; dhold_seen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            fill_blk(1000 + 100*b);
            for (int c = 0; c < 32; c++) send_beat(c);
            push_model();
        end
        bus.d_valid = 1'b0;
        watch_dhold = 1'b0;
        drain();
        chk("stream_d_hold_seen", int'(dhold_seen), 0);
        chk("stream_rows", rows_seen - r0, 24);

        // Consumer stalled while three blocks are offered
        bus.q_hold = 1'b1;
        fill_blk(2000); send_block();
        fill_blk(3000); send_block();
        chk("q_valid_stalled", int'(bus.q_valid), 0);
        fill_blk(4000);
        drive_beat(0);
        chk("full_at_b3_beat0", int'(bus.d_hold), 1);
        bus.q_hold = 1'b0;
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            chk("d_hold_while_draining", int'(bus.d_hold), 1);
        end
        @(posedge clk); #1;
        chk("d_hold_after_row7", int'(bus.d_hold), 0);
        send_block();
        drain();

        // Stall for three cycles on row 3
        fill_blk(-500);
        send_block();
        for (int t = 0; t < 20 && !(bus.q_valid && bus.q_cnt == 3'd3); t++) begin
            @(posedge clk); #1;
        end
        chk("reached_row3", int'(bus.q_cnt), 3);
        bus.q_hold = 1'b1;
        hold_exp = expq[0];
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            chk("hold_q_cnt", int'(bus.q_cnt), 3);
            chk("hold_q_valid", int'(bus.q_valid), 1);
            chk("hold_q0", int'(bus.q[0]), hold_exp.v[0]);
            chk("hold_q7", int'(bus.q[7]), hold_exp.v[7]);
        end
        bus.q_hold = 1'b0;
        @(posedge clk); #1;
        chk("after_hold_q_cnt", int'(bus.q_cnt), 4);
        chk("after_hold_q_valid", int'(bus.q_valid), 1);
        drain();

        // Reset in the middle of block 1 while a row is pending
        fill_blk(200);
        send_block();
        for (int t = 0; t < 5 && !bus.q_valid; t++) begin
            @(posedge clk); #1;
        end
        bus.q_hold = 1'b1;
        fill_blk(700);
        for (int c = 0; c < 18; c++) send_beat(c);
        bus.d_valid = 1'b0;
        chk("pre_reset_q_valid", int'(bus.q_valid), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_q_valid", int'(bus.q_valid), 0);
        chk("mid_rst_d_hold", int'(bus.d_hold), 0);
        chk("mid_rst_q_cnt", int'(bus.q_cnt), 0);
        expq.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.q_hold = 1'b0;
        r0 = rows_seen;
        fill_blk(300);
        send_block();
        drain();
        chk("post_reset_rows", rows_seen - r0, 8);

        // Signed extremes at the first and last zigzag positions
        fill_blk(-20);
        blk[0]  = -16384;
        blk[63] = 16383;
        send_block();
        drain();
        chk("min_at_row0_col0", cap[0][0], -16384);
        chk("max_at_row7_col7", cap[7][7], 16383);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
